fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the single-cycle RV32I core, directly upstream of the main controller. Holds the program counter, issues instruction-memory reads over a ready-based handshake, and presents the latched instruction, its PC and the decoded `Opcode`/`funct3` fields to the controller and datapath. On each retire it computes the next PC from the controller's `PCSel` decision: either PC+4 or the ALU-produced branch/jump target.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be 4-byte aligned.
- `NOP_INST`, default 32'h0000_0013: instruction value presented while no fetch has completed (addi x0,x0,0).

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `PCSel`  in  1  from controller; 1 selects `alu_target`, 0 selects PC+4; sampled only on `retire`.
- `alu_target`  in  32  branch/jal/jalr target from the ALU.
- `retire`  in  1  core has executed the presented instruction this cycle.
- `imem_req`  out  1  read request to instruction memory.
- `imem_addr`  out  32  word-aligned read address.
- `imem_ready`  in  1  memory returns `imem_rdata` this cycle.
- `imem_rdata`  in  32  instruction word; valid only when `imem_ready`=1.
- `inst_valid`  out  1  `inst`/`pc` hold a fetched instruction.
- `inst`  out  32  latched instruction.
- `pc`  out  32  address of `inst`.
- `Opcode`  out  7  `inst[6:0]`.
- `funct3`  out  3  `inst[14:12]`.
- `misalign_err`  out  1  sticky; a taken target had bit 1 set.
- `instret`  out  32  retired-instruction counter.

## Operation
- States: IDLE, FETCH, VALID, HALT.
- IDLE: entered on reset; one cycle, then FETCH. `imem_req`=0.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. On `imem_ready`=1: latch `imem_rdata` into `inst`, go to VALID. Otherwise stay; `imem_addr` must not change while `imem_req`=1.
- VALID: `inst_valid`=1. On `retire`=1: `instret` += 1 (wraps 32'hFFFF_FFFF -> 0); compute next PC; go to FETCH with `pc` updated. Without `retire`, hold all outputs.
- Next PC: `PCSel`=0 -> `pc`+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0). `PCSel`=1 -> `{alu_target[31:1],1'b0}` (jalr bit-0 clear). If `PCSel`=1 and `alu_target[1]`=1: set `misalign_err`, do not update `pc`, go to HALT.
- HALT: `imem_req`=0, `inst_valid`=0; left only by `rst`.
- `retire` outside VALID is ignored (no counter increment, no PC change).
- `imem_ready` outside FETCH is ignored.
- `Opcode`/`funct3` are combinational slices of `inst`.

## Timing
- Reset values: state IDLE, `pc`=`RESET_PC`, `inst`=`NOP_INST`, `inst_valid`=0, `imem_req`=0, `imem_addr`=`RESET_PC`, `misalign_err`=0, `instret`=0.
- `rst` overrides every other input in the same cycle, including mid-fetch and in HALT. An outstanding memory read is abandoned and its late `imem_ready` is ignored, because the block is in IDLE.
- First request: `rst` low at edge E0 -> IDLE during cycle 1 -> `imem_req`=1 in cycle 2.
- Fetch latency: `imem_ready` high in cycle N -> `inst_valid`=1 in cycle N+1. Zero-wait memory gives one instruction per 2 cycles.
- `retire` in cycle M -> FETCH with new `pc`/`imem_addr` in cycle M+1. `inst_valid` is 0 in M+1.
- `misalign_err` is asserted from the cycle after the offending `retire`. `instret` still counts that retire.

## Test plan
- Reset and sequential fetch, memory always ready: `imem_addr` sequence 0x0, 0x4, 0x8. `inst_valid` every other cycle. `instret`=3 after three retires.
- Wait states: `imem_ready` held low 3 cycles -> `imem_req` stays 1 and `imem_addr` stays constant. `inst_valid` rises exactly one cycle after `imem_ready`.
- Taken branch: `PCSel`=1, `alu_target`=0x0000_0100 on retire -> next `imem_addr`=0x100. jalr target 0x0000_0105 -> 0x104.
- Misaligned target 0x0000_0102 with `PCSel`=1: `misalign_err`=1, state HALT, `imem_req`=0, `pc` unchanged. A later `rst` clears everything.
- Edge cases:
  - `retire` pulsed during FETCH: no effect.
  - `pc`=0xFFFF_FFFC with `PCSel`=0: next address 0x0.
  - `instret` preloaded by driving 2^32-1 retires, or a force: wraps to 0.
- `rst` asserted during FETCH with `imem_ready` in the same cycle: `inst`=`NOP_INST`, `inst_valid`=0 next cycle, and the fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/imem_if.sv
// Instruction-memory read port: ready-based request/response between the fetch
// stage (master) and the instruction memory (slave).
interface imem_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: holds the PC, fetches over the imem handshake,
// presents the latched instruction and advances the PC on retire.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         PCSel,
    input  logic [31:0]  alu_target,
    input  logic         retire,
    imem_if.master       imem,
    output logic         inst_valid,
    output logic [31:0]  inst,
    output logic [31:0]  pc,
    output logic [6:0]   Opcode,
    output logic [2:0]   funct3,
    output logic         misalign_err,
    output logic [31:0]  instret
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] instret_q, instret_d;
    logic        err_q, err_d;
    logic        req_q;
    logic        valid_q;

    // Taken targets always have bit 0 cleared, as jalr requires.
    function automatic logic [31:0] taken_target(input logic [31:0] tgt);
        return tgt & 32'hFFFF_FFFE;
    endfunction

    // Bit 1 set on a taken target means it is not word aligned.
    function automatic logic target_misaligned(input logic [31:0] tgt);
        return tgt[1];
    endfunction

    // Next-state, next-PC, instruction latch and retire counter.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        instret_d = instret_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem.imem_ready) begin
                    inst_d  = imem.imem_rdata;
                    state_d = ST_VALID;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_VALID: begin
                if (retire) begin
                    instret_d = instret_q + 32'd1;
                    if (PCSel && target_misaligned(alu_target)) begin
                        err_d   = 1'b1;
                        state_d = ST_HALT;
                    end else if (PCSel) begin
                        pc_d    = taken_target(alu_target);
                        state_d = ST_FETCH;
                    end else begin
                        pc_d    = pc_q + 32'd4;
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_VALID;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; request/valid are registered off the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            inst_q    <= NOP_INST;
            instret_q <= 32'd0;
            err_q     <= 1'b0;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            instret_q <= instret_d;
            err_q     <= err_d;
            req_q     <= (state_d == ST_FETCH);
            valid_q   <= (state_d == ST_VALID);
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign inst_valid     = valid_q;
    assign inst           = inst_q;
    assign pc             = pc_q;
    assign Opcode         = inst_q[6:0];
    assign funct3         = inst_q[14:12];
    assign misalign_err   = err_q;
    assign instret        = instret_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        pcsel;
    logic [31:0] tgt;
    logic        retire;
    logic        ready;
    logic [31:0] rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        misalign_err;
    logic [31:0] instret;

    int checks;
    int failures;

    imem_if bus ();
    assign bus.imem_ready = ready;
    assign bus.imem_rdata = rdata;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (32'h0000_0013)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .PCSel        (pcsel),
        .alu_target   (tgt),
        .retire       (retire),
        .imem         (bus),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .pc           (pc),
        .Opcode       (opcode),
        .funct3       (funct3),
        .misalign_err (misalign_err),
        .instret      (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        pcsel;
        logic [31:0] tgt;
        logic        retire;
        logic        ready;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        err;
        logic [31:0] instret;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic r, input logic ps, input logic [31:0] t, input logic ret,
        input logic rdy, input logic [31:0] rd, input logic q, input logic [31:0] a,
        input logic v, input logic [31:0] i, input logic [31:0] p, input logic e,
        input logic [31:0] n);
        vec_t x;
        x.rst = r; x.pcsel = ps; x.tgt = t; x.retire = ret; x.ready = rdy; x.rdata = rd;
        x.req = q; x.addr = a; x.valid = v; x.inst = i; x.pc = p; x.err = e; x.instret = n;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic ps, input logic [31:0] t,
                        input logic ret, input logic rdy, input logic [31:0] rd);
        rst = r; pcsel = ps; tgt = t; retire = ret; ready = rdy; rdata = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic q, input logic [31:0] a,
                             input logic v, input logic [31:0] i, input logic [31:0] p,
                             input logic e, input logic [31:0] n);
        logic [31:0] iv;
        iv = i;
        check({tag, ".req"},     {31'd0, bus.imem_req}, {31'd0, q});
        check({tag, ".addr"},    bus.imem_addr, a);
        check({tag, ".valid"},   {31'd0, inst_valid}, {31'd0, v});
        check({tag, ".inst"},    inst, i);
        check({tag, ".pc"},      pc, p);
        check({tag, ".opcode"},  {25'd0, opcode}, {25'd0, iv[6:0]});
        check({tag, ".funct3"},  {29'd0, funct3}, {29'd0, iv[14:12]});
        check({tag, ".err"},     {31'd0, misalign_err}, {31'd0, e});
        check({tag, ".instret"}, instret, n);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1; pcsel = 1'b0; tgt = 32'd0; retire = 1'b0; ready = 1'b0; rdata = 32'd0;

        //            rst   ps    tgt            ret   rdy   rdata          req   addr           vld   inst           pc             err   instret
        vecs[0]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0000_0013, 32'h0,         1'b0, 32'd0);
        vecs[1]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0000_0013, 32'h0,         1'b0, 32'd0);
        vecs[2]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0010_0093, 1'b0, 32'h0,         1'b1, 32'h0010_0093, 32'h0,         1'b0, 32'd0);
        vecs[3]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h4,         1'b0, 32'h0010_0093, 32'h4,         1'b0, 32'd1);
        vecs[4]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0020_0113, 1'b0, 32'h4,         1'b1, 32'h0020_0113, 32'h4,         1'b0, 32'd1);
        vecs[5]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h8,         1'b0, 32'h0020_0113, 32'h8,         1'b0, 32'd2);
        vecs[6]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0030_4193, 1'b0, 32'h8,         1'b1, 32'h0030_4193, 32'h8,         1'b0, 32'd2);
        vecs[7]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'hC,         1'b0, 32'h0030_4193, 32'hC,         1'b0, 32'd3);
        // wait states, with a stray retire that must be ignored
        vecs[8]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'hC,         1'b0, 32'h0030_4193, 32'hC,         1'b0, 32'd3);
        vecs[9]  = mk(1'b0, 1'b1, 32'h200,       1'b1, 1'b0, 32'h0,         1'b1, 32'hC,         1'b0, 32'h0030_4193, 32'hC,         1'b0, 32'd3);
        vecs[10] = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'hC,         1'b0, 32'h0030_4193, 32'hC,         1'b0, 32'd3);
        vecs[11] = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_006F, 1'b0, 32'hC,         1'b1, 32'h0000_006F, 32'hC,         1'b0, 32'd3);
        // VALID holds; imem_ready here is ignored
        vecs[12] = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'hC,         1'b1, 32'h0000_006F, 32'hC,         1'b0, 32'd3);
        vecs[13] = mk(1'b0, 1'b1, 32'h100,       1'b1, 1'b0, 32'h0,         1'b1, 32'h100,       1'b0, 32'h0000_006F, 32'h100,       1'b0, 32'd4);
        vecs[14] = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_8067, 1'b0, 32'h100,       1'b1, 32'h0000_8067, 32'h100,       1'b0, 32'd4);
        vecs[15] = mk(1'b0, 1'b1, 32'h105,       1'b1, 1'b0, 32'h0,         1'b1, 32'h104,       1'b0, 32'h0000_8067, 32'h104,       1'b0, 32'd5);
        vecs[16] = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_1063, 1'b0, 32'h104,       1'b1, 32'h0000_1063, 32'h104,       1'b0, 32'd5);
        // misaligned target halts with pc unchanged
        vecs[17] = mk(1'b0, 1'b1, 32'h102,       1'b1, 1'b0, 32'h0,         1'b0, 32'h104,       1'b0, 32'h0000_1063, 32'h104,       1'b1, 32'd6);
        vecs[18] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h1111_1111, 1'b0, 32'h104,       1'b0, 32'h0000_1063, 32'h104,       1'b1, 32'd6);
        vecs[19] = mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0000_0013, 32'h0,         1'b0, 32'd0);
        vecs[20] = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0000_0013, 32'h0,         1'b0, 32'd0);
        // rst during FETCH with imem_ready; the late ready after it is ignored
        vecs[21] = mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'h0,         1'b0, 32'h0000_0013, 32'h0,         1'b0, 32'd0);
        vecs[22] = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h1234_5678, 1'b1, 32'h0,         1'b0, 32'h0000_0013, 32'h0,         1'b0, 32'd0);
        vecs[23] = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0050_0293, 1'b0, 32'h0,         1'b1, 32'h0050_0293, 32'h0,         1'b0, 32'd0);

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].rst, vecs[i].pcsel, vecs[i].tgt, vecs[i].retire, vecs[i].ready, vecs[i].rdata);
            check_all($sformatf("v%0d", i), vecs[i].req, vecs[i].addr, vecs[i].valid,
                      vecs[i].inst, vecs[i].pc, vecs[i].err, vecs[i].instret);
        end

        // PC wrap: jump to 0xFFFF_FFFC, then sequential retire wraps to 0
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0);
        check_all("wrap.jump", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0050_0293, 32'hFFFF_FFFC, 1'b0, 32'd1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0013);
        check_all("wrap.fetch", 1'b0, 32'hFFFF_FFFC, 1'b1, 32'h0000_0013, 32'hFFFF_FFFC, 1'b0, 32'd1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check_all("wrap.seq", 1'b1, 32'h0, 1'b0, 32'h0000_0013, 32'h0, 1'b0, 32'd2);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_2003);
        check_all("cnt.fetch", 1'b0, 32'h0, 1'b1, 32'h0000_2003, 32'h0, 1'b0, 32'd2);

        // instret wrap via a preload force
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        #1;
        check("cnt.preload", instret, 32'hFFFF_FFFF);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check_all("cnt.wrap", 1'b1, 32'h4, 1'b0, 32'h0000_2003, 32'h4, 1'b0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
